// File: rtl/kvt_proj_name_pkg.sv
// Shared types and helpers for the proj_name multi-channel mux wrapper.
package kvt_proj_name_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Channel-id width, never narrower than one bit so a single channel still has an id port.
  function automatic int id_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/kvt_proj_name_chan_fifo.sv
// Per-channel FIFO: power-of-two depth, separate occupancy counter, show-ahead read data.
module kvt_proj_name_chan_fifo
  import kvt_proj_name_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  // Storage carries no reset: contents are only observable through a non-zero count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/kvt_proj_name_mux_wrapper.sv
// N-channel buffered merge: per-channel FIFOs feeding one registered valid/ready output tagged with the source id.
module kvt_proj_name_mux_wrapper
  import kvt_proj_name_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int ARB_MODE = 0,
  localparam int ID_W    = id_w(N_CH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [ID_W-1:0]        out_id,
  output logic [N_CH*CNT_W-1:0]  fill_lvl
);

  // Handshake: a beat moves on an edge where valid & ready are both high; ready never depends on valid.

  logic [N_CH-1:0]   push, pop, full, empty;
  logic [DATA_W-1:0] fifo_rdata [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    kvt_proj_name_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[k]),
      .pop_i   (pop[k]),
      .data_i  (in_data[k*DATA_W +: DATA_W]),
      .data_o  (fifo_rdata[k]),
      .full_o  (full[k]),
      .empty_o (empty[k]),
      .count_o (fill_lvl[k*CNT_W +: CNT_W])
    );
  end

  assign in_ready = ~full;
  assign push     = in_valid & in_ready;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              slot_free, gnt_vld, do_grant;
  logic [ID_W-1:0]   gnt_idx;

  assign slot_free = ~out_valid_q | out_ready;

  // Search order starts at the pointer (round-robin) or at channel 0 (fixed), wrapping modulo N_CH.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      int c;
      logic [ID_W-1:0] c_idx;
      c = (ARB_MODE == int'(ARB_FIXED)) ? i : int'(rr_ptr_q) + i;
      if (c >= N_CH) c = c - N_CH;
      c_idx = ID_W'(c);
      if (!gnt_vld && !empty[c_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = c_idx;
      end
    end
  end

  assign do_grant = slot_free & en & gnt_vld;
  assign pop      = do_grant ? (N_CH'(1) << gnt_idx) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (slot_free) out_valid_d = do_grant;
    if (do_grant) begin
      out_data_d = fifo_rdata[gnt_idx];
      out_id_d   = gnt_idx;
      if (ARB_MODE == int'(ARB_RR))
        rr_ptr_d = (gnt_idx == ID_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_kvt_proj_name_mux_wrapper.sv
// Bench for kvt_proj_name_mux_wrapper: round-robin and fixed-priority instances driven in lock-step against a queue model.
module tb_kvt_proj_name_mux_wrapper;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int CW  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                en = 1'b0;
  logic [NCH-1:0]      in_valid = '0;
  logic [NCH*DW-1:0]   in_data = '0;
  logic                out_ready = 1'b0;

  // index 0 = round-robin instance, index 1 = fixed-priority instance
  logic [1:0]             ov;
  logic [1:0][DW-1:0]     od;
  logic [1:0][1:0]        oid;
  logic [1:0][NCH-1:0]    ir;
  logic [1:0][NCH*CW-1:0] fl;

  kvt_proj_name_mux_wrapper #(.N_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_id(oid[0]), .fill_lvl(fl[0])
  );

  kvt_proj_name_mux_wrapper #(.N_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .ARB_MODE(1)) u_fx (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_id(oid[1]), .fill_lvl(fl[1])
  );

  // ---------------- scoreboard / reference model ----------------
  int n_chk = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_q [2][NCH][$];
  logic          mv  [2];
  logic [DW-1:0] md  [2];
  int            mid [2];
  int            mp  [2];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < NCH; k++) exp_q[m][k].delete();
      mv[m] = 1'b0; md[m] = '0; mid[m] = 0; mp[m] = 0;
    end
  endtask

  // One clock edge of behaviour: winner chosen from pre-edge contents, new beats land behind it.
  task automatic model_step(input int m);
    logic          free;
    int            g;
    logic [NCH-1:0] acc;
    free = !mv[m] || out_ready;
    g = -1;
    if (free && en) begin
      for (int i = 0; i < NCH; i++) begin
        int idx;
        idx = (m == 0) ? (mp[m] + i) % NCH : i;
        if (g < 0 && exp_q[m][idx].size() > 0) g = idx;
      end
    end
    for (int k = 0; k < NCH; k++) acc[k] = in_valid[k] && (exp_q[m][k].size() < DEP);
    if (free) begin
      mv[m] = (g >= 0);
      if (g >= 0) begin
        md[m]  = exp_q[m][g].pop_front();
        mid[m] = g;
        if (m == 0) mp[m] = (g + 1) % NCH;
      end
    end
    for (int k = 0; k < NCH; k++)
      if (acc[k]) exp_q[m][k].push_back(in_data[k*DW +: DW]);
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      string p;
      p = (m == 0) ? "rr" : "fx";
      chk({p, "_out_valid"}, 64'(ov[m]), 64'(mv[m]));
      chk({p, "_out_data"},  64'(od[m]), 64'(md[m]));
      chk({p, "_out_id"},    64'(oid[m]), 64'(mid[m]));
      for (int k = 0; k < NCH; k++) begin
        chk($sformatf("%s_fill%0d", p, k), 64'(fl[m][k*CW +: CW]), 64'(exp_q[m][k].size()));
        chk($sformatf("%s_ready%0d", p, k), 64'(ir[m][k]), 64'(exp_q[m][k].size() < DEP));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  task automatic set_beat(input int ch, input logic [DW-1:0] d);
    in_data[ch*DW +: DW] = d;
  endtask

  logic [1:0] rr_seq [8];
  logic [1:0] fx_seq [8];

  initial begin
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    fx_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    model_reset();

    // reset + idle
    do_reset();
    chk("rst_ready", 64'(ir[0]), 64'h0f);
    chk("rst_valid", 64'(ov[0]), 64'h0);
    tick();

    // single beat on ch2
    en = 1'b1; out_ready = 1'b1;
    set_beat(2, 32'hA5A5_0001);
    in_valid = 4'b0100;
    tick();
    in_valid = '0;
    chk("single_not_early", 64'(ov[0]), 64'h0);
    tick();
    chk("single_valid", 64'(ov[0]), 64'h1);
    chk("single_data", 64'(od[0]), 64'hA5A5_0001);
    chk("single_id", 64'(oid[0]), 64'h2);
    tick();

    // preload 2 beats per channel, then drain with out_ready=1
    do_reset();
    en = 1'b0; out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < NCH; k++) set_beat(k, 32'h1000_0000 | (k << 8) | b);
      in_valid = 4'hF;
      tick();
    end
    in_valid = '0;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_seq%0d_valid", i), 64'(ov[0]), 64'h1);
      chk($sformatf("rr_seq%0d_id", i), 64'(oid[0]), 64'(rr_seq[i]));
      chk($sformatf("fx_seq%0d_id", i), 64'(oid[1]), 64'(fx_seq[i]));
    end
    tick();

    // back-pressure on ch1
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    in_valid = 4'b0010;
    for (int b = 0; b < 5; b++) begin
      set_beat(1, 32'hB000_0000 + b);
      tick();
    end
    chk("bp_fill", 64'(fl[0][1*CW +: CW]), 64'h4);
    chk("bp_ready_low", 64'(ir[0][1]), 64'h0);
    chk("bp_held_data", 64'(od[0]), 64'hB000_0000);
    set_beat(1, 32'hB000_0005);
    tick();
    chk("bp_stable", 64'(od[0]), 64'hB000_0000);
    in_valid = '0;
    out_ready = 1'b1;
    tick();
    chk("bp_ready_back", 64'(ir[0][1]), 64'h1);
    repeat (5) tick();

    // en low: held beat drains, FIFOs keep their contents, grants resume afterwards
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    set_beat(0, 32'hC000_0000); set_beat(3, 32'hC000_0003);
    in_valid = 4'b1001;
    repeat (2) tick();
    in_valid = '0;
    en = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("en_off_valid", 64'(ov[0]), 64'h0);
    en = 1'b1;
    repeat (5) tick();

    // reset asserted mid-operation with buffered beats
    en = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) set_beat(k, $urandom());
    in_valid = 4'b0111;
    tick();
    in_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("midrst_fill", 64'(fl[0]), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // random traffic
    for (int c = 0; c < 800; c++) begin
      in_valid  = NCH'($urandom_range(0, 15));
      for (int k = 0; k < NCH; k++) set_beat(k, $urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 7) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
